// File: rtl/blk_6ee39c.sv
// SHA-256 working variable "a": loads H1 at block start, takes T1+T2 each round.
// Latency: 1 clock from sampled inputs to data_out; data_out is a pure register output.
// Backpressure: none; every rising edge writes, and the controller holds the value by re-presenting it.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset, forces data_out to RESET_VAL
//   control  - 0: load H1, 1: round update with T1+T2
//   H1       - chaining/initial hash word for register a
//   T1, T2   - round temporaries; their sum wraps mod 2^WIDTH
//   data_out - registered current value of working variable a
module blk_6ee39c #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             control,
  input  logic [WIDTH-1:0] H1,
  input  logic [WIDTH-1:0] T1,
  input  logic [WIDTH-1:0] T2,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] round_sum;

  // The carry out of the MSB is dropped by sizing the sum to WIDTH bits.
  assign round_sum = T1 + T2;

  always_comb begin
    data_d = data_q;
    if (control) begin
      data_d = round_sum;
    end else begin
      data_d = H1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_blk_6ee39c.sv
// Directed bench for blk_6ee39c: reset, load, round update, wrap-around,
// mid-cycle input changes, control switching and asynchronous reset.
module tb_blk_6ee39c;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         control;
  logic [W-1:0] H1;
  logic [W-1:0] T1;
  logic [W-1:0] T2;
  logic [W-1:0] data_out;

  int checks;
  int errors;

  blk_6ee39c #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .control  (control),
    .H1       (H1),
    .T1       (T1),
    .T2       (T2),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] expected);
    checks++;
    assert (data_out === expected) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, data_out, expected);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    control = 1'b1;
    H1      = 32'hA5A5A5A5;
    T1      = 32'h12345678;
    T2      = 32'h9ABCDEF0;

    // Reset held across edges with arbitrary inputs.
    #2;
    check("reset_initial", 32'h0);
    tick();
    check("reset_edge1", 32'h0);
    control = 1'b0;
    tick();
    check("reset_edge2", 32'h0);

    // Release between edges, then load H1.
    #2;
    rst_n   = 1'b1;
    control = 1'b0;
    H1      = 32'h01234567;
    T1      = 32'h0000FFFF;
    T2      = 32'hF0F50000;
    tick();
    check("load", 32'h01234567);

    // Load path ignores T inputs.
    T1 = 32'h00FF0000;
    tick();
    check("load_ignores_t", 32'h01234567);

    // Round update.
    control = 1'b1;
    tick();
    check("round_update", 32'hF1F40000);

    // Wrap-around.
    T1 = 32'hFFFFFFFF;
    T2 = 32'h00000002;
    tick();
    check("wrap_carry", 32'h00000001);
    T1 = 32'h80000000;
    T2 = 32'h80000000;
    tick();
    check("wrap_msb", 32'h00000000);

    // Mid-cycle changes do not reach data_out before the next edge.
    #1;
    control = 1'b0;
    H1      = 32'hDEADBEEF;
    T1      = 32'h11111111;
    T2      = 32'h22222222;
    #2;
    check("midcycle_hold", 32'h00000000);
    tick();
    check("midcycle_taken", 32'hDEADBEEF);

    // Control sequence 0,1,1,0.
    control = 1'b0;
    H1      = 32'h11111111;
    tick();
    check("seq_load0", 32'h11111111);
    control = 1'b1;
    T1      = 32'h00000001;
    T2      = 32'h00000002;
    tick();
    check("seq_round1", 32'h00000003);
    T1 = 32'h7FFFFFFF;
    T2 = 32'h7FFFFFFF;
    tick();
    check("seq_round2", 32'hFFFFFFFE);
    control = 1'b0;
    H1      = 32'h22222222;
    tick();
    check("seq_load3", 32'h22222222);

    // Asynchronous reset between edges.
    H1 = 32'h01234567;
    tick();
    check("pre_async", 32'h01234567);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h0);
    tick();
    check("async_reset_held", 32'h0);

    // First edge after release performs the update.
    #2;
    rst_n   = 1'b1;
    control = 1'b1;
    T1      = 32'h00000010;
    T2      = 32'h00000020;
    #1;
    check("release_no_edge", 32'h0);
    tick();
    check("first_edge_after_release", 32'h00000030);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blk_6ee39c.md
Name: a

Overview:
- Working-variable register "a" of a SHA-256 compression datapath.
- At the start of a block it is loaded with the chaining/initial hash word H1.
- On each round it is updated with the round sum T1 + T2 (mod 2^32).
- Sits alongside the other working-variable registers (b..h), driven by the round controller's control strobe.

Parameters:
- WIDTH, 32, datapath word width in bits. All data ports use this width; SHA-256 use is 32.
- RESET_VAL, 0 (all zeros), value loaded into data_out on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- control  input  1  select: 0 = load H1 (initialise), 1 = round update with T1+T2
- H1  input  WIDTH  initial/chaining hash word for register a
- T1  input  WIDTH  SHA-256 round temporary T1
- T2  input  WIDTH  SHA-256 round temporary T2
- data_out  output  WIDTH  registered current value of working variable a

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n).
- rst_n low: data_out = RESET_VAL immediately, independent of clk. Held while rst_n is low.
- rst_n release: synchronous to nothing. The first update occurs on the first rising clk edge with rst_n high.
- Each rising clk edge with rst_n high:
  - control = 0: data_out <= H1.
  - control = 1: data_out <= (T1 + T2) mod 2^WIDTH. The carry out of the MSB is discarded and there is no overflow flag.
- Latency: exactly 1 clock from inputs sampled to data_out.
- data_out is a pure register output, with no combinational path from inputs.
- Inputs changing between edges have no effect on data_out until the next rising edge.
- Only values present at the edge are sampled.
- control is sampled at the same edge as the data. A control change mid-cycle takes effect at the next edge.
- No enable/hold state: every edge writes. The controller holds the value by presenting control = 1 with T1+T2 equal to the desired value, or control = 0 with H1.
- X/unknown on control: no requirement; the controller keeps control defined whenever rst_n is high.
- Reset asserted mid-operation overrides any pending update. data_out returns to RESET_VAL asynchronously.

Test Plan:
1. Reset:
   - Stimulus: rst_n = 0 with arbitrary inputs, clk toggling.
   - Response: data_out = 0x00000000 throughout.
   - Stimulus: assert rst_n = 0 between edges while data_out = 0x01234567.
   - Response: data_out goes to 0 without waiting for a clock edge.
2. Load:
   - Stimulus: rst_n = 1, control = 0, H1 = 0x01234567, T1 = 0x0000FFFF, T2 = 0xF0F50000, one rising edge.
   - Response: data_out = 0x01234567.
3. Load ignores T inputs:
   - Stimulus: keep control = 0, change T1 to 0x00FF0000 between edges, next edge.
   - Response: data_out stays 0x01234567.
4. Round update:
   - Stimulus: control = 1, T1 = 0x00FF0000, T2 = 0xF0F50000, rising edge.
   - Response: data_out = 0xF1F40000.
5. Wrap-around:
   - Stimulus: control = 1, T1 = 0xFFFFFFFF, T2 = 0x00000002, rising edge.
   - Response: data_out = 0x00000001.
   - Stimulus: T1 = 0x80000000, T2 = 0x80000000.
   - Response: data_out = 0x00000000.
6. Mid-cycle input change and switching:
   - Stimulus: change H1/T1/T2/control between edges.
   - Response: data_out unchanged until the next rising edge.
   - Stimulus: control sequence 0,1,1,0 over four edges.
   - Response: data_out = H1, T1+T2, T1+T2 (current values at each edge), H1.
